// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and memory-side bus of the load/store controller.
// The controller uses the slave view; the core/memory environment uses the master view.
interface lsu_ctrl_if #(
   parameter int addr_size = 32,
   parameter int data_size = 32
);
   logic                 req;
   logic                 we;
   logic [1:0]           size;
   logic                 uns;
   logic [addr_size-1:0] addr;
   logic [data_size-1:0] wdata;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [data_size-1:0] rdata;
   logic                 mem_rw;
   logic                 mem_ena;
   logic [addr_size-1:0] mem_addr;
   logic [data_size-1:0] mem_wdata;
   logic [data_size-1:0] mem_rdata;

   modport slave (
      input  req, we, size, uns, addr, wdata, mem_rdata,
      output busy, done, err, rdata, mem_rw, mem_ena, mem_addr, mem_wdata
   );

   modport master (
      output req, we, size, uns, addr, wdata, mem_rdata,
      input  busy, done, err, rdata, mem_rw, mem_ena, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: byte/halfword/word accesses to a big-endian word memory,
// sub-word stores done as read-modify-write, loads sign- or zero-extended.
module lsu_ctrl #(
   parameter int addr_size = 32,
   parameter int data_size = 32
) (
   input logic        clk,
   input logic        rst,
   lsu_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t               state_reg, state_next;
   logic                 we_reg, uns_reg, err_reg;
   logic [1:0]           size_reg;
   logic [addr_size-1:0] addr_reg;
   logic [data_size-1:0] word_reg;
   logic [data_size-1:0] rdata_reg;

   logic                 bad_req;
   logic                 accept;
   logic [7:0]           lane_byte [4];
   logic [3:0]           lane_en;
   logic [data_size-1:0] merged_word;
   logic [7:0]           sel_byte;
   logic [15:0]          sel_half;
   logic [data_size-1:0] load_word;

   assign bad_req = (bus.size == 2'b11)
                 || (bus.size == 2'b01 && bus.addr[0])
                 || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
   assign accept  = (state_reg == IDLE) && bus.req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (bus.req) begin
               if (bad_req)                 state_next = DONE;
               else if (!bus.we)            state_next = READ;
               else if (bus.size == 2'b10)  state_next = WRITE;
               else                         state_next = READ;
            end
         end
         READ:    state_next = we_reg ? WRITE : DONE;
         WRITE:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Lane 0 is the most significant byte (big-endian); a halfword covers lanes {0,1} or {2,3}.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] lane_idx = 2'(gi);
         assign lane_byte[gi] = bus.mem_rdata[31-8*gi -: 8];
         assign lane_en[gi]   = (size_reg == 2'b00) ? (addr_reg[1:0] == lane_idx)
                                                    : (addr_reg[1] == lane_idx[1]);
         assign merged_word[31-8*gi -: 8] =
            !lane_en[gi]                        ? lane_byte[gi] :
            (size_reg == 2'b00 || lane_idx[0])  ? word_reg[7:0] : word_reg[15:8];
      end
   endgenerate

   always_comb begin
      sel_byte  = lane_byte[addr_reg[1:0]];
      sel_half  = addr_reg[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
      load_word = bus.mem_rdata;
      case (size_reg)
         2'b00:   load_word = uns_reg ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
         2'b01:   load_word = uns_reg ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
         default: load_word = bus.mem_rdata;
      endcase
   end

   // word_reg holds the store data, then the merged word once a sub-word read completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_reg    <= 1'b0;
         uns_reg   <= 1'b0;
         err_reg   <= 1'b0;
         size_reg  <= 2'b00;
         addr_reg  <= '0;
         word_reg  <= '0;
         rdata_reg <= '0;
      end else begin
         if (accept) begin
            we_reg   <= bus.we;
            uns_reg  <= bus.uns;
            err_reg  <= bad_req;
            size_reg <= bus.size;
            addr_reg <= bus.addr;
            word_reg <= bus.wdata;
         end
         if (state_reg == READ) begin
            if (we_reg) word_reg  <= merged_word;
            else        rdata_reg <= load_word;
         end
      end
   end

   assign bus.busy      = (state_reg != IDLE);
   assign bus.done      = (state_reg == DONE);
   assign bus.err       = (state_reg == DONE) && err_reg;
   assign bus.rdata     = rdata_reg;
   assign bus.mem_ena   = (state_reg == READ);
   assign bus.mem_rw    = (state_reg == WRITE);
   assign bus.mem_addr  = (state_reg == READ || state_reg == WRITE)
                        ? {addr_reg[addr_size-1:2], 2'b00} : '0;
   assign bus.mem_wdata = (state_reg == WRITE) ? word_reg : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a byte-array reference model predicts each response,
// a monitor checks done/err/rdata/latency/memory traffic as the controller presents them.
module tb_lsu_ctrl;
   logic clk;
   logic rst;

   lsu_ctrl_if #(.addr_size(32), .data_size(32)) bus();

   lsu_ctrl #(.addr_size(32), .data_size(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          err;
      logic [31:0] rdata;
      int          lat;
      int          acc;
      int          n_ena;
      int          n_rw;
      logic [31:0] waddr;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          ena_cnt = 0;
   int          rw_cnt = 0;
   int          bad_cnt = 0;
   logic [31:0] mem_w [16];
   logic [7:0]  ref_b [64];
   logic [31:0] ref_rdata = 32'h0;

   assign bus.mem_rdata = mem_w[bus.mem_addr[5:2]];

   function automatic logic [31:0] init_word(int k);
      logic [31:0] t;
      t = 32'(k + 1);
      return (32'h9E3779B9 * t) ^ 32'h5A5A0F0F;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Memory + monitor: the write is captured mid-cycle and committed at the closing edge.
   initial begin : monitor
      exp_t        e;
      bit          wr_pend;
      logic [3:0]  wr_idx;
      logic [31:0] wr_data;
      for (int k = 0; k < 16; k++) mem_w[k] = init_word(k);
      forever begin
         @(negedge clk);
         wr_pend = rst && bus.mem_rw;
         wr_idx  = bus.mem_addr[5:2];
         wr_data = bus.mem_wdata;
         @(posedge clk);
         if (wr_pend) mem_w[wr_idx] = wr_data;
         cyc++;
         #1;
         if (rst) begin
            if (bus.mem_ena) ena_cnt++;
            if (bus.mem_rw)  rw_cnt++;
            if (bus.mem_ena || bus.mem_rw) begin
               if (bus.mem_ena && bus.mem_rw) bad_cnt++;
               if (sb.size() == 0) bad_cnt++;
               else if (bus.mem_addr !== sb[0].waddr) bad_cnt++;
            end else if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
               bad_cnt++;
            end
            if (bus.done) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL spurious_done: got done=1 with nothing outstanding, required done=0");
               end else begin
                  e = sb.pop_front();
                  chk("err", 32'(bus.err), 32'(e.err));
                  chk("rdata", bus.rdata, e.rdata);
                  chk("busy_at_done", 32'(bus.busy), 32'h1);
                  chk("latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
                  chk("mem_ena_cycles", 32'(ena_cnt), 32'(e.n_ena));
                  chk("mem_rw_cycles", 32'(rw_cnt), 32'(e.n_rw));
                  chk("bus_violations", 32'(bad_cnt), 32'h0);
                  $display("[TB] txn done: err=%0b rdata=%h lat=%0d", bus.err, bus.rdata, cyc + 1 - e.acc);
               end
               ena_cnt = 0;
               rw_cnt  = 0;
               bad_cnt = 0;
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy) begin
         @(negedge clk);
         n++;
         if (n > 30) begin
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", bus.busy, n);
            $fatal(1, "controller never returned to idle");
         end
      end
   endtask

   task automatic issue(bit w, bit [1:0] sz, bit u, logic [31:0] a, logic [31:0] wd, bit noise);
      exp_t        e;
      bit          bad;
      int          n;
      logic [31:0] v;
      wait_idle();
      bad     = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      n       = 1 << sz;
      e.err   = bad;
      e.acc   = cyc + 1;
      e.waddr = {a[31:2], 2'b00};
      e.n_ena = 0;
      e.n_rw  = 0;
      if (bad) begin
         e.lat = 1;
      end else if (!w) begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[a + i]);
         if (!u && n == 1 && v[7])  v = v | 32'hFFFFFF00;
         if (!u && n == 2 && v[15]) v = v | 32'hFFFF0000;
         ref_rdata = v;
         e.n_ena   = 1;
         e.lat     = 2;
      end else begin
         for (int i = 0; i < n; i++) ref_b[a + i] = wd[8*(n-1-i) +: 8];
         e.n_rw  = 1;
         e.n_ena = (sz == 2'b10) ? 0 : 1;
         e.lat   = (sz == 2'b10) ? 2 : 3;
      end
      e.rdata = ref_rdata;
      sb.push_back(e);
      $display("[TB] issue we=%0b size=%0d uns=%0b addr=%h wdata=%h noise=%0b", w, sz, u, a, wd, noise);
      bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd; bus.req = 1'b1;
      @(negedge clk);
      bus.req   = 1'b0;
      bus.we    = 1'($urandom);
      bus.size  = 2'($urandom);
      bus.uns   = 1'($urandom);
      bus.addr  = $urandom;
      bus.wdata = $urandom;
      if (noise) begin
         bus.req   = 1'b1;
         bus.we    = 1'b1;
         bus.addr  = $urandom_range(0, 63);
         @(negedge clk);
         bus.req = 1'b0;
      end
   endtask

   initial begin : driver
      logic [31:0] old;
      for (int k = 0; k < 16; k++)
         for (int j = 0; j < 4; j++) ref_b[4*k + j] = init_word(k) >> (8 * (3 - j));
      bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
      bus.addr = 32'h0; bus.wdata = 32'h0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_mem_rw", 32'(bus.mem_rw), 32'h0);
      chk("rst_mem_ena", 32'(bus.mem_ena), 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
      issue(0, 2'b10, 0, 32'h10, 32'h0, 0);
      issue(1, 2'b10, 0, 32'h10, 32'h12F45678, 0);
      issue(0, 2'b00, 0, 32'h11, 32'h0, 0);
      issue(0, 2'b00, 1, 32'h11, 32'h0, 0);
      issue(1, 2'b10, 0, 32'h10, 32'h11223344, 0);
      issue(1, 2'b01, 0, 32'h12, 32'h0000ABCD, 0);
      issue(0, 2'b10, 0, 32'h10, 32'h0, 0);
      issue(0, 2'b10, 0, 32'h13, 32'h0, 0);
      issue(0, 2'b11, 0, 32'h10, 32'h0, 0);
      issue(0, 2'b10, 0, 32'h10, 32'h0, 1);

      // Reset while the word store to 0x20 sits in WRITE: nothing may reach memory.
      wait_idle();
      old = mem_w[8];
      bus.we = 1'b1; bus.size = 2'b10; bus.uns = 1'b0; bus.addr = 32'h20; bus.wdata = ~old;
      bus.req = 1'b1;
      @(posedge clk);
      #3;
      bus.req = 1'b0;
      chk("rw_before_reset", 32'(bus.mem_rw), 32'h1);
      rst = 1'b0;
      #1;
      chk("rw_after_reset", 32'(bus.mem_rw), 32'h0);
      chk("busy_after_reset", 32'(bus.busy), 32'h0);
      chk("addr_after_reset", bus.mem_addr, 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("mem_0x20_kept", mem_w[8], old);
      chk("rdata_after_reset", bus.rdata, 32'h0);
      ref_rdata = 32'h0;
      sb.delete();
      ena_cnt = 0; rw_cnt = 0; bad_cnt = 0;
      @(negedge clk);
      rst = 1'b1;
      issue(0, 2'b10, 0, 32'h20, 32'h0, 0);

      for (int t = 0; t < 200; t++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 63), $urandom,
               ($urandom_range(0, 3) == 0));
      end

      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      for (int k = 0; k < 16; k++)
         chk($sformatf("mem_word_%0d", k), mem_w[k],
             {ref_b[4*k], ref_b[4*k+1], ref_b[4*k+2], ref_b[4*k+3]});
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter addr_size, default 32, meaning the address width in bits.
REQ-002 The block SHALL have parameter data_size, default 32, meaning the data word width; only 32 is supported.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  asynchronous active-low reset (0 = reset).
REQ-006 Port req  input  1  core access request, sampled only in IDLE.
REQ-007 Port we  input  1  1 = store, 0 = load.
REQ-008 Port size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 Port uns  input  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 Port addr  input  addr_size  byte address.
REQ-011 Port wdata  input  32  store data, right-justified for byte and halfword.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port done  output  1  one-cycle completion pulse.
REQ-014 Port err  output  1  misaligned or illegal-size flag, valid with done.
REQ-015 Port rdata  output  32  load result, extended.
REQ-016 Port mem_rw  output  1  memory write strobe (full word at mem_addr..mem_addr+3).
REQ-017 Port mem_ena  output  1  memory read enable.
REQ-018 Port mem_addr  output  addr_size  word-aligned memory address.
REQ-019 Port mem_wdata  output  32  memory write data.
REQ-020 Port mem_rdata  input  32  combinational memory read data.

Function
REQ-021 The memory SHALL be treated as big-endian: byte offset 0 maps to bits 31:24, offset 3 to bits 7:0; halfword offset 0 maps to bits 31:16, offset 2 to bits 15:0.
REQ-022 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-023 In IDLE with req=1, the block SHALL latch we, size, uns, addr and wdata, then transition.
REQ-024 Transition targets SHALL be: illegal or misaligned -> DONE; load -> READ; word store -> WRITE; byte or halfword store -> READ.
REQ-025 Misalignment SHALL be defined as: halfword with addr[0]=1, or word with addr[1:0]!=00; size=11 SHALL always be illegal.
REQ-026 READ SHALL last one cycle with mem_ena=1 and mem_addr={addr[31:2],2'b00}.
REQ-027 For a load, READ SHALL capture the selected lane into rdata, extended per uns, then go to DONE.
REQ-028 For a sub-word store, READ SHALL capture mem_rdata, merge the wdata lane into it, then go to WRITE.
REQ-029 WRITE SHALL last one cycle with mem_rw=1, mem_ena=0, and mem_wdata equal to the merged word (or wdata for a word store), then go to DONE.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE; err=1 only for illegal or misaligned requests.
REQ-031 Latency from the accepting edge to done SHALL be: error 1 cycle, load 2 cycles, word store 2 cycles, sub-word store 3 cycles.
REQ-032 Erroneous requests SHALL never assert mem_rw or mem_ena, and SHALL leave rdata unchanged.
REQ-033 mem_rw, mem_ena, mem_addr and mem_wdata SHALL be decoded from state only (Moore); mem_addr and mem_wdata SHALL be 0 when not in READ or WRITE.
REQ-034 req while busy=1 SHALL be ignored, with no queueing.
REQ-035 rdata SHALL hold its value until the next load completes; stores SHALL not modify rdata.
REQ-036 req asserted in the cycle done=1 SHALL be ignored; it is accepted in the following IDLE cycle.

Reset
REQ-037 rst=0 SHALL immediately force IDLE, busy=0, done=0, err=0, rdata=0, mem_rw=0, mem_ena=0, mem_addr=0, mem_wdata=0.
REQ-038 Reset asserted during WRITE SHALL deassert mem_rw asynchronously, so no memory write occurs at the next edge; the latched request SHALL be discarded.
REQ-039 After rst returns to 1, the first req SHALL be accepted at the first rising edge.

Verification
REQ-040 Word store then load: store addr=0x10, wdata=0xDEADBEEF -> mem_rw one cycle, mem_addr=0x10, done at T+2; then load word at 0x10 -> rdata=0xDEADBEEF at T+2, err=0.
REQ-041 Signed byte load: memory word at 0x10=0x12F45678, load byte addr=0x11 uns=0 -> rdata=0xFFFFFFF4; with uns=1 -> rdata=0x000000F4.
REQ-042 Halfword read-modify-write: memory word 0x11223344, store half addr=0x12, wdata=0x0000ABCD -> READ then WRITE with mem_wdata=0x1122ABCD, done at T+3.
REQ-043 Misaligned access: load word addr=0x13 -> done with err=1 at T+1, no mem_ena or mem_rw pulse, rdata unchanged; size=11 gives the same response.
REQ-044 Reset mid-WRITE: drop rst during the WRITE cycle of a store to 0x20 -> mem_rw falls immediately, memory at 0x20 is unchanged, busy=0.
REQ-045 Busy collision: pulse req with a new store during READ of a load -> the store is ignored, and only one done is seen.
